// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: operands are split into STAGES chunks, one chunk is summed per
// register stage, and the carry ripples stage to stage. All stages advance together on a valid/ready stream.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Index k is the input side of stage k; index STAGES is the output of the last stage.
    logic [STAGES:0]            w_v;
    logic [STAGES:0]            w_c;
    logic [STAGES:0][WIDTH-1:0] w_a;
    logic [STAGES:0][WIDTH-1:0] w_b;
    logic [STAGES:0][WIDTH-1:0] w_s;
    logic                       w_adv;
    logic                       w_unused;

    assign w_adv    = !w_v[STAGES] | out_ready;
    assign in_ready = w_adv;

    // Subtraction folds into addition: invert B and the carry-in once, at the entry.
    assign w_v[0] = in_valid;
    assign w_a[0] = a;
    assign w_b[0] = b ^ {WIDTH{sub}};
    assign w_c[0] = cin ^ sub;
    assign w_s[0] = '0;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [CHUNK:0]     w_add;
            logic [WIDTH-1:0]   w_snext;
            logic               r_v;
            logic               r_c;
            logic [WIDTH-1:0]   r_a;
            logic [WIDTH-1:0]   r_b;
            logic [WIDTH-1:0]   r_s;

            assign w_add = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, w_c[k]};

            always_comb begin
                w_snext = w_s[k];
                w_snext[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
            end

            // Operands travel whole; only chunk k of the partial sum is replaced here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                end else if (w_adv) begin
                    r_v <= w_v[k];
                    r_c <= w_add[CHUNK];
                    r_a <= w_a[k];
                    r_b <= w_b[k];
                    r_s <= w_snext;
                end
            end

            assign w_v[k+1] = r_v;
            assign w_c[k+1] = r_c;
            assign w_a[k+1] = r_a;
            assign w_b[k+1] = r_b;
            assign w_s[k+1] = r_s;
        end
    endgenerate

    // Finished operand chunks are never read again.
    assign w_unused = ^{w_a, w_b};

    assign out_valid = w_v[STAGES];
    assign sum       = w_s[STAGES];
    assign cout      = w_c[STAGES];
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: four adder configurations share one handshake; each result is checked
// for value and exact arrival cycle against an arithmetic model.
module tb_pipelined_adder;
    logic        clk;
    logic        rst;
    logic        tb_valid;
    logic        tb_ordy;
    logic        tb_sub;
    logic        tb_cin;
    logic [15:0] tb_a;
    logic [15:0] tb_b;
    logic        dut_iv;
    logic [3:0]  o_r;
    logic [3:0]  o_v;
    logic [3:0]  o_c;
    logic [7:0]  s0, s1, s2;
    logic [15:0] s3;
    logic [15:0] o_sum [4];

    typedef struct {
        logic [16:0] res;
        int          cyc;
        int          holds;
    } exp_t;

    exp_t        exp_q [4][$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          hold_cnt [4];
    logic [3:0]  prev_hold;
    logic [16:0] prev_act [4];
    logic        done;

    assign dut_iv   = tb_valid & (&o_r);
    assign o_sum[0] = {8'h00, s0};
    assign o_sum[1] = {8'h00, s1};
    assign o_sum[2] = {8'h00, s2};
    assign o_sum[3] = s3;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(dut_iv), .in_ready(o_r[0]), .sub(tb_sub),
        .a(tb_a[7:0]), .b(tb_b[7:0]), .cin(tb_cin), .out_valid(o_v[0]),
        .out_ready(tb_ordy), .sum(s0), .cout(o_c[0]));
    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(dut_iv), .in_ready(o_r[1]), .sub(tb_sub),
        .a(tb_a[7:0]), .b(tb_b[7:0]), .cin(tb_cin), .out_valid(o_v[1]),
        .out_ready(tb_ordy), .sum(s1), .cout(o_c[1]));
    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(dut_iv), .in_ready(o_r[2]), .sub(tb_sub),
        .a(tb_a[7:0]), .b(tb_b[7:0]), .cin(tb_cin), .out_valid(o_v[2]),
        .out_ready(tb_ordy), .sum(s2), .cout(o_c[2]));
    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(dut_iv), .in_ready(o_r[3]), .sub(tb_sub),
        .a(tb_a), .b(tb_b), .cin(tb_cin), .out_valid(o_v[3]),
        .out_ready(tb_ordy), .sum(s3), .cout(o_c[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stg(input int d);
        case (d)
            0: return 2;
            1: return 1;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    // Plain integer arithmetic: {cout, sum}; in sub mode cout=1 means no borrow.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic s, input int w);
        longint unsigned mask, ea, eb, r;
        logic co;
        logic [16:0] out;
        mask = (64'd1 << w) - 64'd1;
        ea = longint'(a) & mask;
        eb = longint'(b) & mask;
        if (!s) begin
            r  = ea + eb + longint'(c);
            co = ((r >> w) != 0);
        end else begin
            co = (ea >= eb + longint'(c));
            r  = ea - eb - longint'(c);
        end
        r = r & mask;
        out = {co, r[15:0]};
        return out;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk);
        #1;
        tb_a = a; tb_b = b; tb_cin = c; tb_sub = s; tb_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (dut_iv) begin
                for (int d = 0; d < 4; d++) begin
                    e.res   = model(a, b, c, s, (d == 3) ? 16 : 8);
                    e.cyc   = cyc;
                    e.holds = hold_cnt[d];
                    exp_q[d].push_back(e);
                end
                break;
            end
            n++;
            if (n > 50) begin
                checks++; fails++;
                $display("FAIL accept_timeout: in_ready=%b, need all ready within 50 cycles", o_r);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 tb_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Monitor: pops on each output handshake, checks value, arrival cycle, and stall behaviour.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                logic [16:0] act;
                exp_t e;
                int want;
                act = {o_c[d], o_sum[d]};
                if (prev_hold[d]) begin
                    checks++;
                    if (!o_v[d] || act != prev_act[d]) begin
                        fails++;
                        $display("FAIL stall_hold dut%0d: got v=%0b res=%h, need v=1 res=%h",
                                 d, o_v[d], act, prev_act[d]);
                    end
                end
                if (o_v[d] && !tb_ordy) begin
                    checks++;
                    hold_cnt[d]++;
                    if (o_r[d]) begin
                        fails++;
                        $display("FAIL stall_in_ready dut%0d: got 1, need 0", d);
                    end
                end
                if (o_v[d] && tb_ordy) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_out dut%0d: got res=%h, need no output", d, act);
                    end else begin
                        e = exp_q[d].pop_front();
                        want = e.cyc + stg(d) + (hold_cnt[d] - e.holds);
                        if (act != e.res || cyc != want) begin
                            fails++;
                            $display("FAIL result dut%0d: got res=%h cyc=%0d, need res=%h cyc=%0d",
                                     d, act, cyc, e.res, want);
                        end
                    end
                end
                prev_hold[d] = o_v[d] && !tb_ordy;
                prev_act[d]  = act;
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; tb_valid = 1'b0; tb_ordy = 1'b1; done = 1'b0;
        tb_a = '0; tb_b = '0; tb_cin = 1'b0; tb_sub = 1'b0;
        for (int d = 0; d < 4; d++) hold_cnt[d] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (o_v[d] || o_c[d] || o_sum[d] != 16'h0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got v=%0b c=%0b sum=%h, need 0 0 0",
                         d, o_v[d], o_c[d], o_sum[d]);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_r != 4'hF) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, need 1111", o_r);
        end

        // Directed corners, each from an empty pipe.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle(10);
        send(16'h0080, 16'h0080, 1'b1, 1'b0); idle(10);
        send(16'h0005, 16'h0007, 1'b0, 1'b1); idle(10);
        send(16'h0007, 16'h0005, 1'b0, 1'b1); idle(10);

        // Backpressure: out_ready drops for 3 cycles once the first result shows.
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
                idle(1);
            end
            begin
                n = 0;
                while (!o_v[0] && n < 50) begin @(negedge clk); n++; end
                @(posedge clk);
                #1 tb_ordy = 1'b0;
                repeat (3) @(posedge clk);
                #1 tb_ordy = 1'b1;
            end
        join
        idle(12);

        // Full rate: 16 back-to-back beats.
        for (int i = 0; i < 16; i++) send_rand();
        idle(12);

        // Random gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) idle(0);
                end
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 tb_ordy = ($urandom_range(0, 3) != 0);
                end
                tb_ordy = 1'b1;
            end
        join
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && n < 200) begin
            @(posedge clk); n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("FAIL drain: got %0d beats outstanding, need 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        end

        // Reset with beats in flight: outputs clear at once, nothing stale afterwards.
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
        @(posedge clk);
        #1 tb_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            exp_q[d].delete();
            checks++;
            if (o_v[d] || o_c[d] || o_sum[d] != 16'h0) begin
                fails++;
                $display("FAIL reset_midstream dut%0d: got v=%0b c=%0b sum=%h, need 0 0 0",
                         d, o_v[d], o_c[d], o_sum[d]);
            end
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (o_r != 4'hF) begin
            fails++;
            $display("FAIL ready_after_midreset: got %b, need 1111", o_r);
        end
        repeat (12) @(posedge clk);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(12);
        checks++;
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0) begin
            fails++;
            $display("FAIL final_drain: got %0d beats outstanding, need 0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
